// File: rtl/md_ctrl_pkg.sv
// Shared op, read and select codes for the E-stage multiply/divide sequencer.
package md_ctrl_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_t;

  localparam logic [1:0] RD_NONE = 2'b00;
  localparam logic [1:0] RD_LO   = 2'b01;
  localparam logic [1:0] RD_HI   = 2'b10;

  localparam logic [2:0] SEL_ALU = 3'b000;
  localparam logic [2:0] SEL_LO  = 3'b001;
  localparam logic [2:0] SEL_HI  = 3'b010;

  function automatic logic is_md_start(input md_op_t op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_md_div(input md_op_t op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_ctrl_if.sv
// E-stage side of the multiply/divide unit: op/operands in, HI/LO, stall and mux select out.
interface md_ctrl_if;
  import md_ctrl_pkg::*;

  md_op_t      md_op;
  logic [1:0]  md_rd;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        md_use_D;
  logic        busy;
  logic        stall_D;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [2:0]  m_aluoutE_sel;

  modport master (
    output md_op, md_rd, src_a, src_b, md_use_D,
    input  busy, stall_D, hi, lo, m_aluoutE_sel
  );

  modport slave (
    input  md_op, md_rd, src_a, src_b, md_use_D,
    output busy, stall_D, hi, lo, m_aluoutE_sel
  );
endinterface

// File: rtl/md_calc.sv
// Combinational multiply/divide datapath producing the {hi,lo} result and a divide-by-zero flag.
module md_calc
  import md_ctrl_pkg::*;
(
  input  md_op_t      op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] res,
  output logic        div0
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] div_a;
  logic [31:0] div_b;
  logic [31:0] quo_u;
  logic [31:0] rem_u;
  logic        sgn_div;

  assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign prod_u = {32'd0, a} * {32'd0, b};

  // Signed divide runs on magnitudes so 0x80000000 / -1 wraps back to 0x80000000 naturally.
  assign sgn_div = (op == MD_DIV);
  assign mag_a   = (sgn_div && a[31]) ? (~a + 32'd1) : a;
  assign mag_b   = (sgn_div && b[31]) ? (~b + 32'd1) : b;
  assign div_a   = mag_a;
  assign div_b   = (b == 32'd0) ? 32'd1 : mag_b;
  assign quo_u   = div_a / div_b;
  assign rem_u   = div_a % div_b;

  always_comb begin
    res  = 64'd0;
    div0 = is_md_div(op) && (b == 32'd0);
    case (op)
      MD_MULT:  res = prod_s;
      MD_MULTU: res = prod_u;
      MD_DIV: begin
        res[31:0]  = (a[31] ^ b[31]) ? (~quo_u + 32'd1) : quo_u;
        res[63:32] = a[31] ? (~rem_u + 32'd1) : rem_u;
      end
      MD_DIVU:  res = {rem_u, quo_u};
      default:  res = 64'd0;
    endcase
  end

endmodule

// File: rtl/md_ctrl.sv
// Multiply/divide sequencer: owns HI/LO, models mult/div latency, raises the D-stage stall.
//   state  | meaning
//   S_IDLE | no operation in flight; mthi/mtlo and starts accepted
//   S_RUN  | counter draining; pending {hi,lo} committed when it reaches 1
module md_ctrl
  import md_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic     clk,
  input  logic     reset_n,
  md_ctrl_if.slave md
);

  localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [63:0]      pend, pend_nxt;
  logic             pend_ok, pend_ok_nxt;
  logic [31:0]      hi_q, hi_nxt;
  logic [31:0]      lo_q, lo_nxt;
  logic [63:0]      calc_res;
  logic             calc_div0;
  logic             start_now;

  md_calc u_calc (
    .op   (md.md_op),
    .a    (md.src_a),
    .b    (md.src_b),
    .res  (calc_res),
    .div0 (calc_div0)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      pend    <= '0;
      pend_ok <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      pend    <= pend_nxt;
      pend_ok <= pend_ok_nxt;
      hi_q    <= hi_nxt;
      lo_q    <= lo_nxt;
    end
  end

  assign start_now = (state == S_IDLE) && is_md_start(md.md_op);

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    pend_nxt    = pend;
    pend_ok_nxt = pend_ok;
    hi_nxt      = hi_q;
    lo_nxt      = lo_q;
    case (state)
      S_IDLE: begin
        if (start_now) begin
          pend_nxt    = calc_res;
          pend_ok_nxt = !calc_div0;
          cnt_nxt     = is_md_div(md.md_op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
          state_nxt   = S_RUN;
        end else if (md.md_op == MD_MTHI) begin
          hi_nxt = md.src_a;
        end else if (md.md_op == MD_MTLO) begin
          lo_nxt = md.src_a;
        end
      end
      S_RUN: begin
        // Ops arriving here are illegal under stall and are dropped, completion wins.
        if (cnt == CNT_W'(1)) begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
          if (pend_ok) begin
            hi_nxt = pend[63:32];
            lo_nxt = pend[31:0];
          end
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    case (md.md_rd)
      RD_LO:   md.m_aluoutE_sel = SEL_LO;
      RD_HI:   md.m_aluoutE_sel = SEL_HI;
      default: md.m_aluoutE_sel = SEL_ALU;
    endcase
  end

  assign md.busy    = (state == S_RUN);
  assign md.stall_D = md.md_use_D && (md.busy || start_now);
  assign md.hi      = hi_q;
  assign md.lo      = lo_q;

endmodule

// File: tb/tb_md_ctrl.sv
// Directed bench for md_ctrl: latency, arithmetic, stall window, mthi/mtlo and mux select.
module tb_md_ctrl;
  import md_ctrl_pkg::*;

  logic clk;
  logic reset_n;
  int   total;
  int   bad;

  md_ctrl_if mif ();

  md_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .md      (mif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Inputs change 2 time units after the active edge; checks happen 1 unit later.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input md_op_t op, input logic [31:0] a, input logic [31:0] b);
    mif.md_op = op;
    mif.src_a = a;
    mif.src_b = b;
  endtask

  // Launch op, hold busy window of n cycles, then expect hi/lo.
  task automatic run_op(input string tag, input md_op_t op, input logic [31:0] a,
                        input logic [31:0] b, input int n,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    drive(op, a, b);
    tick();
    drive(MD_NONE, 32'h0, 32'h0);
    for (int i = 0; i < n; i++) begin
      #1 chk({tag, "_busy"}, 32'(mif.busy), 32'd1);
      tick();
    end
    #1;
    chk({tag, "_idle"}, 32'(mif.busy), 32'd0);
    chk({tag, "_hi"}, mif.hi, exp_hi);
    chk({tag, "_lo"}, mif.lo, exp_lo);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset_n      = 1'b0;
    mif.md_rd    = RD_NONE;
    mif.md_use_D = 1'b0;
    drive(MD_NONE, 32'h0, 32'h0);
    #12;
    chk("rst_hi", mif.hi, 32'h0);
    chk("rst_lo", mif.lo, 32'h0);
    chk("rst_busy", 32'(mif.busy), 32'd0);
    chk("rst_sel", 32'(mif.m_aluoutE_sel), 32'(SEL_ALU));
    reset_n = 1'b1;
    tick();

    // mthi / mtlo and the read select
    drive(MD_MTHI, 32'h12345678, 32'h0);
    #1 chk("mthi_nobusy", 32'(mif.busy), 32'd0);
    tick();
    drive(MD_MTLO, 32'hCAFEF00D, 32'h0);
    mif.md_rd = RD_HI;
    #1;
    chk("mthi_hi", mif.hi, 32'h12345678);
    chk("sel_hi", 32'(mif.m_aluoutE_sel), 32'(SEL_HI));
    tick();
    drive(MD_NONE, 32'h0, 32'h0);
    mif.md_rd = RD_LO;
    #1;
    chk("mtlo_lo", mif.lo, 32'hCAFEF00D);
    chk("mtlo_busy", 32'(mif.busy), 32'd0);
    chk("sel_lo", 32'(mif.m_aluoutE_sel), 32'(SEL_LO));
    mif.md_rd = 2'b11;
    #1 chk("sel_11", 32'(mif.m_aluoutE_sel), 32'(SEL_ALU));
    mif.md_rd = RD_NONE;
    #1 chk("sel_none", 32'(mif.m_aluoutE_sel), 32'(SEL_ALU));

    // reset mid-operation aborts the mult and clears HI/LO
    tick();
    drive(MD_MULT, 32'h00000003, 32'h00000004);
    tick();
    drive(MD_NONE, 32'h0, 32'h0);
    tick();
    tick();
    reset_n = 1'b0;
    #1;
    chk("abort_hi", mif.hi, 32'h0);
    chk("abort_lo", mif.lo, 32'h0);
    chk("abort_busy", 32'(mif.busy), 32'd0);
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    #1;
    chk("abort_late_lo", mif.lo, 32'h0);
    chk("abort_late_busy", 32'(mif.busy), 32'd0);

    // mult with stall window: start cycle plus 5 busy cycles
    tick();
    mif.md_use_D = 1'b1;
    drive(MD_MULT, 32'hFFFFFFFF, 32'h00000002);
    #1 chk("stall_start", 32'(mif.stall_D), 32'd1);
    tick();
    drive(MD_NONE, 32'h0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      #1 chk("stall_busy", 32'(mif.stall_D), 32'd1);
      tick();
    end
    #1;
    chk("stall_drop", 32'(mif.stall_D), 32'd0);
    chk("mult_hi", mif.hi, 32'hFFFFFFFF);
    chk("mult_lo", mif.lo, 32'hFFFFFFFE);
    mif.md_use_D = 1'b0;
    #1 chk("nouse_nostall", 32'(mif.stall_D), 32'd0);

    tick();
    run_op("multu", MD_MULTU, 32'hFFFFFFFF, 32'h00000002, 5, 32'h00000001, 32'hFFFFFFFE);
    tick();
    run_op("div", MD_DIV, 32'hFFFFFFF9, 32'h00000002, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
    tick();
    run_op("divu0", MD_DIVU, 32'h00000007, 32'h00000000, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
    tick();
    run_op("divovf", MD_DIV, 32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000);
    tick();
    run_op("divu", MD_DIVU, 32'd100, 32'd7, 10, 32'd2, 32'd14);

    // completion edge collides with mthi: result must win
    tick();
    drive(MD_MULTU, 32'h00010000, 32'h00010000);
    tick();
    drive(MD_NONE, 32'h0, 32'h0);
    for (int i = 0; i < 4; i++) tick();
    drive(MD_MTHI, 32'hDEADBEEF, 32'h0);
    tick();
    drive(MD_NONE, 32'h0, 32'h0);
    #1;
    chk("collide_hi", mif.hi, 32'h00000001);
    chk("collide_lo", mif.lo, 32'h00000000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
